// File: rtl/instr_queue.sv
// Instruction assembler and queue: gathers short/long instructions from a byte
// stream and presents them FIFO-ordered to a consumer.
module instr_queue #(
  parameter int DATA_W    = 8,
  parameter int OP_W      = 3,
  parameter int EXT_BYTES = 1,
  parameter int DEPTH     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OP_W-1:0]               ins,
  output logic [DATA_W-OP_W-1:0]        ad1,
  output logic [EXT_BYTES*DATA_W-1:0]   ad2,
  output logic                          long_op,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int AD1_W = DATA_W - OP_W;
  localparam int AD2_W = EXT_BYTES * DATA_W;
  localparam int ENT_W = 1 + OP_W + AD1_W + AD2_W;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int EC_W  = (EXT_BYTES > 1) ? $clog2(EXT_BYTES) : 1;

  typedef enum logic {ST_HEAD = 1'b0, ST_EXT = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [AD1_W-1:0]   opnd_q, opnd_d;
  logic [AD2_W-1:0]   ext_q, ext_d;
  logic [EC_W-1:0]    ecnt_q, ecnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ENT_W-1:0]   mem_q [DEPTH];

  logic               accept_s, pop_s, push_s;
  logic [ENT_W-1:0]   push_ent_s;

  assign in_ready  = rst & ~flush & (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != {CNT_W{1'b0}});
  assign count     = count_q;
  assign accept_s  = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready & ~flush;

  // Decoder FSM: assemble instruction fields and decide when an entry is complete
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    opnd_d     = opnd_q;
    ext_d      = ext_q;
    ecnt_d     = ecnt_q;
    push_s     = 1'b0;
    push_ent_s = {ENT_W{1'b0}};
    if (flush) begin
      state_d = ST_HEAD;
      op_d    = {OP_W{1'b0}};
      opnd_d  = {AD1_W{1'b0}};
      ext_d   = {AD2_W{1'b0}};
      ecnt_d  = {EC_W{1'b0}};
    end else if (accept_s) begin
      case (state_q)
        ST_HEAD: begin
          if (data[DATA_W-1]) begin
            op_d    = data[DATA_W-1 -: OP_W];
            opnd_d  = data[AD1_W-1:0];
            ext_d   = {AD2_W{1'b0}};
            ecnt_d  = {EC_W{1'b0}};
            state_d = ST_EXT;
          end else begin
            push_s     = 1'b1;
            push_ent_s = {1'b0, data[DATA_W-1 -: OP_W], data[AD1_W-1:0], {AD2_W{1'b0}}};
          end
        end
        ST_EXT: begin
          // Extension bytes are placed most-significant first
          for (int k = 0; k < EXT_BYTES; k++) begin
            if (ecnt_q == EC_W'(k)) begin
              ext_d[AD2_W-1-k*DATA_W -: DATA_W] = data;
            end else begin
              ext_d[AD2_W-1-k*DATA_W -: DATA_W] = ext_d[AD2_W-1-k*DATA_W -: DATA_W];
            end
          end
          if (ecnt_q == EC_W'(EXT_BYTES - 1)) begin
            push_s     = 1'b1;
            push_ent_s = {1'b1, op_q, opnd_q, ext_d};
            state_d    = ST_HEAD;
          end else begin
            ecnt_d = ecnt_q + EC_W'(1);
          end
        end
        default: state_d = ST_HEAD;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Queue bookkeeping: occupancy and wrapping pointers
  always_comb begin
    count_d = count_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (flush) begin
      count_d = {CNT_W{1'b0}};
      wptr_d  = {PTR_W{1'b0}};
      rptr_d  = {PTR_W{1'b0}};
    end else begin
      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
      if (push_s) wptr_d = wptr_q + PTR_W'(1); else wptr_d = wptr_q;
      if (pop_s)  rptr_d = rptr_q + PTR_W'(1); else rptr_d = rptr_q;
    end
  end

  // Head entry is blanked whenever the queue is empty
  always_comb begin
    if (out_valid) begin
      {long_op, ins, ad1, ad2} = mem_q[rptr_q];
    end else begin
      {long_op, ins, ad1, ad2} = {ENT_W{1'b0}};
    end
  end

  // Control and partial-instruction registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_HEAD;
      op_q    <= {OP_W{1'b0}};
      opnd_q  <= {AD1_W{1'b0}};
      ext_q   <= {AD2_W{1'b0}};
      ecnt_q  <= {EC_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      wptr_q  <= {PTR_W{1'b0}};
      rptr_q  <= {PTR_W{1'b0}};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      ext_q   <= ext_d;
      ecnt_q  <= ecnt_d;
      count_q <= count_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
    end
  end

  // Entry storage; contents are only observed while occupied
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wptr_q] <= push_ent_s;
    end
  end

endmodule

// File: tb/tb_instr_queue.sv
// Directed testbench for instr_queue with default parameters.
module tb_instr_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] ins;
  logic [4:0] ad1;
  logic [7:0] ad2;
  logic       long_op;
  logic [2:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  instr_queue dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .data(data), .out_valid(out_valid), .out_ready(out_ready), .ins(ins), .ad1(ad1),
    .ad2(ad2), .long_op(long_op), .count(count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", count); end
    n_tests++; if ({ins, ad1, ad2, long_op} !== 17'd0) begin n_fail++; $display("FAIL rst_fields got %h exp 0", {ins, ad1, ad2, long_op}); end
    @(negedge clk); rst = 1'b1;
    step();
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rel_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_short();
    in_valid = 1'b1; data = 8'h5C; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL short_valid got %b exp 1", out_valid); end
    n_tests++; if (ins !== 3'b010 || ad1 !== 5'b11100) begin n_fail++; $display("FAIL short_fields got ins=%b ad1=%b exp 010 11100", ins, ad1); end
    n_tests++; if (ad2 !== 8'h00 || long_op !== 1'b0) begin n_fail++; $display("FAIL short_ext got ad2=%h long=%b exp 00 0", ad2, long_op); end
    n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL short_count got %0d exp 1", count); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_tests++; if (count !== 3'd0 || out_valid !== 1'b0 || ins !== 3'd0) begin n_fail++; $display("FAIL short_pop got cnt=%0d v=%b ins=%b exp 0 0 000", count, out_valid, ins); end
  endtask

  task automatic test_long();
    in_valid = 1'b1; data = 8'hBC;
    step();
    n_tests++; if (out_valid !== 1'b0 || count !== 3'd0) begin n_fail++; $display("FAIL long_partial got v=%b cnt=%0d exp 0 0", out_valid, count); end
    data = 8'hAF;
    step();
    in_valid = 1'b0;
    n_tests++; if (out_valid !== 1'b1 || ins !== 3'b101 || ad1 !== 5'b11100) begin n_fail++; $display("FAIL long_head got v=%b ins=%b ad1=%b exp 1 101 11100", out_valid, ins, ad1); end
    n_tests++; if (ad2 !== 8'hAF || long_op !== 1'b1) begin n_fail++; $display("FAIL long_ext got ad2=%h long=%b exp AF 1", ad2, long_op); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL long_pop got %0d exp 0", count); end
  endtask

  task automatic test_full();
    in_valid = 1'b1;
    data = 8'h01; step();
    data = 8'h22; step();
    data = 8'h43; step();
    data = 8'h64; step();
    n_tests++; if (count !== 3'd4 || in_ready !== 1'b0) begin n_fail++; $display("FAIL full_state got cnt=%0d rdy=%b exp 4 0", count, in_ready); end
    data = 8'h05; step();
    in_valid = 1'b0;
    n_tests++; if (count !== 3'd4 || ins !== 3'b000 || ad1 !== 5'b00001) begin n_fail++; $display("FAIL full_reject got cnt=%0d ins=%b ad1=%b exp 4 000 00001", count, ins, ad1); end
    out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_same_cycle_rdy got %b exp 0", in_ready); end
    step();
    out_ready = 1'b0;
    n_tests++; if (count !== 3'd3 || in_ready !== 1'b1) begin n_fail++; $display("FAIL full_pop got cnt=%0d rdy=%b exp 3 1", count, in_ready); end
    n_tests++; if (ins !== 3'b001 || ad1 !== 5'b00010) begin n_fail++; $display("FAIL full_head2 got ins=%b ad1=%b exp 001 00010", ins, ad1); end
    out_ready = 1'b1; step();
    n_tests++; if (ins !== 3'b010 || ad1 !== 5'b00011) begin n_fail++; $display("FAIL full_head3 got ins=%b ad1=%b exp 010 00011", ins, ad1); end
    step();
    n_tests++; if (ins !== 3'b011 || ad1 !== 5'b00100) begin n_fail++; $display("FAIL full_head4 got ins=%b ad1=%b exp 011 00100", ins, ad1); end
    step();
    out_ready = 1'b0;
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL full_drain got %0d exp 0", count); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1;
    data = 8'h11; step();
    data = 8'h12; step();
    data = 8'h13; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL b2b_count got %0d exp 2", count); end
    n_tests++; if (ad1 !== 5'b10010) begin n_fail++; $display("FAIL b2b_head1 got ad1=%b exp 10010", ad1); end
    step();
    n_tests++; if (ad1 !== 5'b10011 || count !== 3'd1) begin n_fail++; $display("FAIL b2b_head2 got ad1=%b cnt=%0d exp 10011 1", ad1, count); end
    step();
    out_ready = 1'b0;
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL b2b_drain got %0d exp 0", count); end
  endtask

  task automatic test_flush();
    in_valid = 1'b1;
    data = 8'h21; step();
    data = 8'h22; step();
    data = 8'hBC; step();
    n_tests++; if (count !== 3'd2) begin n_fail++; $display("FAIL flush_pre got %0d exp 2", count); end
    flush = 1'b1; data = 8'hAF; out_ready = 1'b1;
    #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_rdy got %b exp 0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_clear got cnt=%0d v=%b exp 0 0", count, out_valid); end
    in_valid = 1'b1; data = 8'h5C;
    step();
    in_valid = 1'b0;
    n_tests++; if (count !== 3'd1 || long_op !== 1'b0 || ins !== 3'b010 || ad1 !== 5'b11100) begin n_fail++; $display("FAIL flush_head got cnt=%0d long=%b ins=%b ad1=%b exp 1 0 010 11100", count, long_op, ins, ad1); end
    out_ready = 1'b1; step(); out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    data = 8'h5C; step();
    data = 8'hBC; step();
    in_valid = 1'b0;
    n_tests++; if (count !== 3'd1) begin n_fail++; $display("FAIL arst_pre got %0d exp 1", count); end
    #2 rst = 1'b0;
    #1;
    n_tests++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_ctrl got cnt=%0d v=%b rdy=%b exp 0 0 0", count, out_valid, in_ready); end
    n_tests++; if ({ins, ad1, ad2, long_op} !== 17'd0) begin n_fail++; $display("FAIL arst_fields got %h exp 0", {ins, ad1, ad2, long_op}); end
    @(negedge clk); rst = 1'b1;
    step();
    n_tests++; if (count !== 3'd0) begin n_fail++; $display("FAIL arst_empty got %0d exp 0", count); end
    in_valid = 1'b1; data = 8'h5C;
    step();
    in_valid = 1'b0;
    n_tests++; if (count !== 3'd1 || long_op !== 1'b0 || ins !== 3'b010) begin n_fail++; $display("FAIL arst_head got cnt=%0d long=%b ins=%b exp 1 0 010", count, long_op, ins); end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 8, fetch byte width (>= OP_W+1).
REQ-002 SHALL have parameter OP_W, default 3, opcode field width.
REQ-003 SHALL have parameter EXT_BYTES, default 1, extension bytes per long instruction (1..4).
REQ-004 SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, >= 2).
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-007 SHALL have port flush, input, 1, synchronous discard of queue and partial instruction.
REQ-008 SHALL have port in_valid, input, 1, fetch byte present on data.
REQ-009 SHALL have port in_ready, output, 1, block accepts a byte this cycle.
REQ-010 SHALL have port data, input, DATA_W, fetched byte from register file or RAM/ROM.
REQ-011 SHALL have port out_valid, output, 1, head instruction present.
REQ-012 SHALL have port out_ready, input, 1, consumer takes the head instruction.
REQ-013 SHALL have port ins, output, OP_W, head opcode.
REQ-014 SHALL have port ad1, output, DATA_W-OP_W, head short address/operand.
REQ-015 SHALL have port ad2, output, EXT_BYTES*DATA_W, head extended address.
REQ-016 SHALL have port long_op, output, 1, head is a long instruction.
REQ-017 SHALL have port count, output, $clog2(DEPTH+1), occupied entries.

Function
REQ-018 SHALL accept a byte when in_valid and in_ready are both 1 on a rising edge.
REQ-019 SHALL drive in_ready = rst and !flush and (count < DEPTH), with no dependence on out_ready.
REQ-020 SHALL implement FSM states HEAD and EXT; after reset the state is HEAD.
REQ-021 In HEAD, an accepted byte SHALL split as opcode = data[DATA_W-1 -: OP_W], operand = data[DATA_W-OP_W-1:0].
REQ-022 An opcode with MSB 0 SHALL be short: push {opcode, operand, ad2=0, long_op=0} on the same edge; state stays HEAD.
REQ-023 An opcode with MSB 1 SHALL be long: latch opcode/operand, clear the extension byte counter, and go to EXT.
REQ-024 In EXT, accepted bytes SHALL fill ad2 MSB-first; the first extension byte lands in ad2[EXT_BYTES*DATA_W-1 -: DATA_W].
REQ-025 On acceptance of extension byte EXT_BYTES, the block SHALL push {opcode, operand, ad2, long_op=1} and return to HEAD.
REQ-026 No queue entry SHALL be visible before its final byte is accepted; out_valid SHALL rise one cycle after the push edge.
REQ-027 The queue SHALL be FIFO-ordered; read and write pointers wrap modulo DEPTH.
REQ-028 A pop SHALL occur when out_valid and out_ready are both 1; out_valid = (count != 0).
REQ-029 ins, ad1, ad2 and long_op SHALL show the head entry while out_valid=1, and all zeros while count=0.
REQ-030 A push and a pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-031 A pop at count=DEPTH SHALL raise in_ready on the next cycle, not the same cycle.
REQ-032 flush=1 SHALL, on the next edge, set count=0, reset both pointers, return the FSM to HEAD and drop any partial instruction.
REQ-033 flush SHALL take priority over a push or pop in the same cycle; the consumer's pop that cycle has no effect.

Reset
REQ-034 While rst=0, the block SHALL immediately and asynchronously force: FSM=HEAD, count=0, pointers=0, partial registers=0, in_ready=0, out_valid=0, ins/ad1/ad2/long_op=0.
REQ-035 Reset mid-instruction or with a non-empty queue SHALL discard all content; after rst rises, the first accepted byte is a HEAD byte.

Verification (defaults DATA_W=8, OP_W=3, EXT_BYTES=1, DEPTH=4)
REQ-036 Short push: out_ready=0, accept 0x5C -> next cycle out_valid=1, ins=010, ad1=11100, ad2=0x00, long_op=0, count=1.
REQ-037 Long push: accept 0xBC -> out_valid stays 0; then accept 0xAF -> next cycle ins=101, ad1=11100, ad2=0xAF, long_op=1.
REQ-038 Full: four short bytes with out_ready=0 -> count=4, in_ready=0, fifth byte not accepted; one pop -> count=3, in_ready=1 on the following cycle.
REQ-039 Simultaneous push and pop at count=2 -> count stays 2; heads pop in insertion order.
REQ-040 Flush after 0xBC with two entries queued -> count=0, out_valid=0; next byte 0x5C is decoded as a short HEAD byte.
REQ-041 Drive rst low between clock edges with the queue non-empty -> all outputs zero before the next edge; no entries remain after release.
